al422_bam_row_sequencer: RTL
============================

AL422_BAM_ROW_SEQUENCER -- requirements
Module: al422_bam_row_sequencer

Interface
REQ-001 The block SHALL have parameter ROW_COUNT, default 16, meaning the number of panel rows per frame (at least 2).
REQ-002 The block SHALL have parameter BIT_DEPTH, default 8, meaning the bit planes per row (1..8).
REQ-003 The block SHALL have parameter BASE_OE_TICKS, default 4, meaning the display clocks for bit plane 0.
REQ-004 The block SHALL have derived parameter ROW_W = $clog2(ROW_COUNT).
REQ-005 in_clk  input  1  sole clock; all logic is on the rising edge.
REQ-006 in_nrst  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  run request; sampled only at step boundaries.
REQ-008 module_is_busy  input  1  first-stage busy flag.
REQ-009 row_data_ready  input  1  first-stage shift complete (level).
REQ-010 module_start  output  1  one-cycle start pulse to first stage.
REQ-011 bit_counter  output  3  bit plane currently shifting; held stable from start until shift done.
REQ-012 from_zero_address  output  1  rewind the AL422 read pointer; valid with module_start.
REQ-013 led_lat  output  1  panel latch pulse, active high.
REQ-014 led_oe  output  1  panel output enable, active low.
REQ-015 row_addr  output  ROW_W  displayed row address.
REQ-016 frame_done  output  1  one-cycle pulse when the last plane of the last row is latched.

Function
REQ-017 AL422 layout SHALL be row-major with each row stored BIT_DEPTH times; step order is bit 0..BIT_DEPTH-1 within a row, then the next row.
REQ-018 FSM states SHALL be IDLE, START, WAIT_BUSY, SHIFT, WAIT_DISP and LATCH.
REQ-019 IDLE->START SHALL occur when enable=1 and module_is_busy=0.
REQ-020 In START, module_start SHALL be 1 for exactly one cycle, and from_zero_address SHALL be 1 when (row,bit)=(0,0); the next state is WAIT_BUSY.
REQ-021 WAIT_BUSY->SHIFT SHALL occur on module_is_busy=1, so that a stale row_data_ready is never accepted.
REQ-022 SHIFT->WAIT_DISP SHALL occur on row_data_ready=1 and module_is_busy=0.
REQ-023 WAIT_DISP->LATCH SHALL occur when the display counter is 0; the display of the previous plane overlaps the shift of the next.
REQ-024 LATCH SHALL last one cycle, with led_lat=1, led_oe=1 (blank), and row_addr set to the step's row.
REQ-025 The cycle after LATCH, the display counter SHALL load BASE_OE_TICKS<<bit, and led_oe SHALL be 0 while the counter is nonzero, decrementing once per cycle.
REQ-026 After LATCH, the (row,bit) step SHALL advance; on wrap from (ROW_COUNT-1,BIT_DEPTH-1) to (0,0), frame_done SHALL pulse in the LATCH cycle.
REQ-027 After LATCH, the next state SHALL be START if enable=1, else IDLE.
REQ-028 On re-entry from IDLE, the step SHALL reset to (0,0), so the first start always carries from_zero_address=1.
REQ-029 An enable drop mid-step SHALL NOT abort the step: the current shift completes and is latched and displayed, and then the block idles.
REQ-030 The display counter width SHALL hold BASE_OE_TICKS<<(BIT_DEPTH-1) without overflow.

Reset
REQ-031 On in_nrst=0, the block SHALL enter IDLE with step (0,0) and display counter 0.
REQ-032 On in_nrst=0, the outputs SHALL be: module_start=0, from_zero_address=0, led_lat=0, led_oe=1, row_addr=0, bit_counter=0 and frame_done=0.
REQ-033 Reset SHALL take effect immediately at any point, including mid-shift and mid-display.

Structure
REQ-034 The FSM state encoding and the step-order constant SHALL reside in a shared package al422_bam_pkg.
REQ-035 The display-time counter SHALL be a sub-module al422_bam_oe_timer (load, count and busy), instantiated once.

Verification
REQ-036 Frame start (ROW_COUNT=4, BIT_DEPTH=8, BASE=2, enable=1, first stage modelled): the first module_start SHALL carry from_zero_address=1 and bit_counter=0, and later starts SHALL carry from_zero_address=0.
REQ-037 BAM weights (same setup): led_oe low runs SHALL last 2, 4, 8, ... 256 cycles for bits 0..7, each preceded by one led_lat cycle with led_oe=1.
REQ-038 Row wrap: after 32 latches, frame_done SHALL pulse once, row_addr SHALL go 3->0 on the next latch, and the next start SHALL have from_zero_address=1.
REQ-039 Stale ready (row_data_ready held high from the prior row when start is issued): the block SHALL stay in WAIT_BUSY until busy=1 and SHALL NOT latch early.
REQ-040 Enable dropped during the bit-3 shift: bit 3 SHALL be latched and displayed for 16 cycles, then no further module_start SHALL occur; re-enable SHALL restart at (0,0).
REQ-041 Reset asserted mid-display: led_oe=1 and row_addr=0 SHALL appear immediately, with no pulse on any output until enable restarts the sequence.

Source files
------------

// File: rtl/al422_bam_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// al422_bam_pkg : shared FSM encoding and step-order constants.  Rev 1.0
// -----------------------------------------------------------------------------
package al422_bam_pkg;

  localparam int C_STATE_W = 3;
  typedef logic [C_STATE_W-1:0] state_t;

  localparam state_t C_ST_IDLE      = 3'd0;
  localparam state_t C_ST_START     = 3'd1;
  localparam state_t C_ST_WAIT_BUSY = 3'd2;
  localparam state_t C_ST_SHIFT     = 3'd3;
  localparam state_t C_ST_WAIT_DISP = 3'd4;
  localparam state_t C_ST_LATCH     = 3'd5;

  // Each row is stored BIT_DEPTH times; steps walk bit planes upward, then rows.
  localparam int C_BIT_W = 3;
  localparam logic [C_BIT_W-1:0] C_FIRST_BIT = 3'd0;

endpackage
`default_nettype wire

// File: rtl/al422_bam_oe_timer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// al422_bam_oe_timer : down-counter timing the lit period of one bit plane.  Rev 1.0
// -----------------------------------------------------------------------------
module al422_bam_oe_timer #(
  parameter int CNT_W = 10
) (
  input  logic             in_clk,
  input  logic             in_nrst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             busy
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign busy = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/al422_bam_row_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// al422_bam_row_sequencer : BAM row/bit-plane sequencer for an AL422-fed LED panel.  Rev 1.0
// -----------------------------------------------------------------------------
module al422_bam_row_sequencer
  import al422_bam_pkg::*;
#(
  parameter int ROW_COUNT     = 16,
  parameter int BIT_DEPTH     = 8,
  parameter int BASE_OE_TICKS = 4,
  parameter int ROW_W         = $clog2(ROW_COUNT)
) (
  input  logic             in_clk,
  input  logic             in_nrst,
  input  logic             enable,
  input  logic             module_is_busy,
  input  logic             row_data_ready,
  output logic             module_start,
  output logic [2:0]       bit_counter,
  output logic             from_zero_address,
  output logic             led_lat,
  output logic             led_oe,
  output logic [ROW_W-1:0] row_addr,
  output logic             frame_done
);

  localparam int C_MAX_TICKS = BASE_OE_TICKS << (BIT_DEPTH - 1);
  localparam int C_CNT_W     = $clog2(C_MAX_TICKS + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [ROW_W-1:0]   r_row;
  logic [C_BIT_W-1:0] r_bit;
  logic [ROW_W-1:0]   r_row_addr;
  logic               w_last_bit;
  logic               w_last_row;
  logic               w_oe_busy;
  logic [C_CNT_W-1:0] w_oe_ticks;

  assign w_last_bit = (r_bit == C_BIT_W'(BIT_DEPTH - 1));
  assign w_last_row = (r_row == ROW_W'(ROW_COUNT - 1));
  assign w_oe_ticks = C_CNT_W'(BASE_OE_TICKS) << r_bit;

  al422_bam_oe_timer #(
    .CNT_W (C_CNT_W)
  ) u_oe_timer (
    .in_clk     (in_clk),
    .in_nrst    (in_nrst),
    .load       (r_state == C_ST_LATCH),
    .load_value (w_oe_ticks),
    .busy       (w_oe_busy)
  );

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // WAIT_BUSY guards against a ready level left over from the previous shift.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_ST_IDLE:      if (enable && !module_is_busy) w_next_state = C_ST_START;
      C_ST_START:     w_next_state = C_ST_WAIT_BUSY;
      C_ST_WAIT_BUSY: if (module_is_busy) w_next_state = C_ST_SHIFT;
      C_ST_SHIFT:     if (row_data_ready && !module_is_busy) w_next_state = C_ST_WAIT_DISP;
      C_ST_WAIT_DISP: if (!w_oe_busy) w_next_state = C_ST_LATCH;
      C_ST_LATCH:     w_next_state = enable ? C_ST_START : C_ST_IDLE;
      default:        w_next_state = C_ST_IDLE;
    endcase
  end

  // Step advances in LATCH; leaving for IDLE rewinds so the next run starts at (0,0).
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      r_row      <= '0;
      r_bit      <= C_FIRST_BIT;
      r_row_addr <= '0;
    end else begin
      if (w_next_state == C_ST_LATCH) begin
        r_row_addr <= r_row;
      end
      if (r_state == C_ST_IDLE) begin
        r_row <= '0;
        r_bit <= C_FIRST_BIT;
      end else if (r_state == C_ST_LATCH) begin
        if (!enable) begin
          r_row <= '0;
          r_bit <= C_FIRST_BIT;
        end else if (w_last_bit) begin
          r_bit <= C_FIRST_BIT;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_bit <= r_bit + 1'b1;
        end
      end
    end
  end

  always_comb begin
    module_start      = 1'b0;
    from_zero_address = 1'b0;
    led_lat           = 1'b0;
    frame_done        = 1'b0;
    led_oe            = !w_oe_busy;
    case (r_state)
      C_ST_START: begin
        module_start      = 1'b1;
        from_zero_address = (r_row == '0) && (r_bit == C_FIRST_BIT);
      end
      C_ST_LATCH: begin
        led_lat    = 1'b1;
        led_oe     = 1'b1;
        frame_done = w_last_row && w_last_bit;
      end
      default: ;
    endcase
  end

  assign bit_counter = r_bit;
  assign row_addr    = r_row_addr;

endmodule
`default_nettype wire
